// File: rtl/pc_predict_ras.sv
// Fetch-stage PC generator: registered PC, taken-jXX/call prediction, and a circular
// return-address stack with a jXX checkpoint, redirected by execute/memory corrections.
module pc_predict_ras #(
  parameter int              AW        = 64,
  parameter int              RAS_DEPTH = 8,
  parameter logic [AW-1:0]   RESET_PC  = '0
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         F_stall,
  input  logic                         f_valid,
  input  logic [3:0]                   f_icode,
  input  logic [AW-1:0]                f_valC,
  input  logic [AW-1:0]                f_valP,
  input  logic                         jxx_mispredict,
  input  logic [AW-1:0]                jxx_fall_pc,
  input  logic                         ret_resolve,
  input  logic [AW-1:0]                ret_actual_pc,
  input  logic [AW-1:0]                ret_pred_pc,
  output logic [AW-1:0]                PC,
  output logic [AW-1:0]                pred_pc,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_overflow,
  output logic                         ret_mispredict
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [3:0]    IC_JXX  = 4'h7;
  localparam logic [3:0]    IC_CALL = 4'h8;
  localparam logic [3:0]    IC_RET  = 4'h9;
  localparam logic [CW-1:0] FULL    = CW'(RAS_DEPTH);

  logic [AW-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0] tos_ptr;
  logic [PW-1:0] ckpt_ptr;
  logic [CW-1:0] ckpt_count;

  logic          is_jxx, is_call, is_ret;
  logic          ret_wrong, advance;
  logic          do_push, do_pop, do_ckpt;
  logic [AW-1:0] ras_top;

  // tos_ptr names the next free slot; when full that slot is the oldest entry.
  always_comb begin
    is_jxx    = f_valid && (f_icode == IC_JXX);
    is_call   = f_valid && (f_icode == IC_CALL);
    is_ret    = f_valid && (f_icode == IC_RET) && (ras_count != '0);
    ras_top   = ras_mem[tos_ptr - PW'(1)];
    ret_wrong = ret_resolve && (ret_actual_pc != ret_pred_pc);
    advance   = !F_stall && !ret_wrong && !jxx_mispredict;
    do_push   = advance && is_call;
    do_pop    = advance && is_ret;
    do_ckpt   = advance && is_jxx;
    pred_pc   = f_valP;
    if (is_jxx || is_call) begin
      pred_pc = f_valC;
    end else if (is_ret) begin
      pred_pc = ras_top;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      PC             <= RESET_PC;
      tos_ptr        <= '0;
      ras_count      <= '0;
      ckpt_ptr       <= '0;
      ckpt_count     <= '0;
      ras_overflow   <= 1'b0;
      ret_mispredict <= 1'b0;
    end else begin
      ret_mispredict <= ret_wrong;
      if (ret_wrong) begin
        PC        <= ret_actual_pc;
        ras_count <= '0;
      end else if (jxx_mispredict) begin
        // Pointer and count come back; slots overwritten on the wrong path stay overwritten.
        PC        <= jxx_fall_pc;
        tos_ptr   <= ckpt_ptr;
        ras_count <= ckpt_count;
      end else if (!F_stall) begin
        PC <= pred_pc;
        if (do_ckpt) begin
          ckpt_ptr   <= tos_ptr;
          ckpt_count <= ras_count;
        end
        if (do_push) begin
          tos_ptr <= tos_ptr + PW'(1);
          if (ras_count == FULL) begin
            ras_overflow <= 1'b1;
          end else begin
            ras_count <= ras_count + CW'(1);
          end
        end else if (do_pop) begin
          tos_ptr   <= tos_ptr - PW'(1);
          ras_count <= ras_count - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (do_push) begin
      ras_mem[tos_ptr] <= f_valP;
    end
  end

endmodule

// File: tb/tb_pc_predict_ras.sv
// Bench for pc_predict_ras: directed scenarios with literal expectations plus a random
// run checked against a return-stack model kept in plain integer arithmetic.
module tb_pc_predict_ras;

  localparam int D = 8;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic        F_stall, f_valid, jxx_mispredict, ret_resolve;
  logic [3:0]  f_icode;
  logic [63:0] f_valC, f_valP, jxx_fall_pc, ret_actual_pc, ret_pred_pc;
  logic [63:0] PC, pred_pc;
  logic [3:0]  ras_count;
  logic        ras_overflow, ret_mispredict;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: stack contents by slot, next-free slot, depth, checkpoint.
  logic [63:0] m_pc;
  logic [63:0] m_mem [D];
  int          m_ptr, m_cnt, m_ck_ptr, m_ck_cnt;
  logic        m_ovf, m_rm;

  pc_predict_ras #(.AW(64), .RAS_DEPTH(D), .RESET_PC(64'h0)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .F_stall(F_stall), .f_valid(f_valid),
    .f_icode(f_icode), .f_valC(f_valC), .f_valP(f_valP),
    .jxx_mispredict(jxx_mispredict), .jxx_fall_pc(jxx_fall_pc),
    .ret_resolve(ret_resolve), .ret_actual_pc(ret_actual_pc), .ret_pred_pc(ret_pred_pc),
    .PC(PC), .pred_pc(pred_pc), .ras_count(ras_count),
    .ras_overflow(ras_overflow), .ret_mispredict(ret_mispredict)
  );

  always #5 Clk = ~Clk;

  function automatic logic [63:0] model_pred();
    if (!f_valid) return f_valP;
    case (f_icode)
      4'h7, 4'h8: return f_valC;
      4'h9:       return (m_cnt > 0) ? m_mem[(m_ptr + D - 1) % D] : f_valP;
      default:    return f_valP;
    endcase
  endfunction

  task automatic model_reset();
    m_pc = 64'h0; m_ptr = 0; m_cnt = 0; m_ck_ptr = 0; m_ck_cnt = 0;
    m_ovf = 1'b0; m_rm = 1'b0;
  endtask

  task automatic idle();
    F_stall = 0; f_valid = 0; f_icode = 4'h1; f_valC = 0; f_valP = 0;
    jxx_mispredict = 0; jxx_fall_pc = 0; ret_resolve = 0; ret_actual_pc = 0; ret_pred_pc = 0;
  endtask

  task automatic fetch(input logic [3:0] ic, input logic [63:0] vc, input logic [63:0] vp);
    f_valid = 1; f_icode = ic; f_valC = vc; f_valP = vp;
  endtask

  // One clock: the model consumes the inputs present at the edge; returns #1 after it.
  task automatic tick();
    logic [63:0] p;
    logic        wrong;
    p = model_pred();
    wrong = ret_resolve && (ret_actual_pc != ret_pred_pc);
    @(posedge Clk);
    m_rm = wrong;
    if (wrong) begin
      m_pc = ret_actual_pc; m_cnt = 0;
    end else if (jxx_mispredict) begin
      m_pc = jxx_fall_pc; m_ptr = m_ck_ptr; m_cnt = m_ck_cnt;
    end else if (!F_stall) begin
      m_pc = p;
      if (f_valid && f_icode == 4'h7) begin
        m_ck_ptr = m_ptr; m_ck_cnt = m_cnt;
      end else if (f_valid && f_icode == 4'h8) begin
        m_mem[m_ptr] = f_valP;
        m_ptr = (m_ptr + 1) % D;
        if (m_cnt == D) m_ovf = 1'b1;
        else m_cnt = m_cnt + 1;
      end else if (f_valid && f_icode == 4'h9 && m_cnt > 0) begin
        m_ptr = (m_ptr + D - 1) % D;
        m_cnt = m_cnt - 1;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    Reset_n = 0;
    #1;
    model_reset();
    @(posedge Clk);
    #1;
    Reset_n = 1;
    idle();
  endtask

  task automatic test_reset();
    idle();
    #2 Reset_n = 0;
    #1;
    n_checks++; if (PC !== 64'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", PC); end
    n_checks++; if (ras_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", ras_count); end
    n_checks++; if (ret_mispredict !== 1'b0) begin n_fail++; $display("FAIL reset_rm: got %b want 0", ret_mispredict); end
    model_reset();
    @(posedge Clk); #1; Reset_n = 1;
    for (int i = 0; i < 9; i++) begin
      fetch(4'h8, 64'h500 + 64'(i), 64'h600 + 64'(i));
      tick();
    end
    n_checks++; if (ras_overflow !== 1'b1) begin n_fail++; $display("FAIL pre_reset_ovf: got %b want 1", ras_overflow); end
    Reset_n = 0;
    #1;
    n_checks++; if (PC !== 64'h0) begin n_fail++; $display("FAIL async_reset_pc: got %h want 0", PC); end
    n_checks++; if (ras_count !== 4'd0) begin n_fail++; $display("FAIL async_reset_count: got %0d want 0", ras_count); end
    n_checks++; if (ras_overflow !== 1'b0) begin n_fail++; $display("FAIL async_reset_ovf: got %b want 0", ras_overflow); end
    model_reset();
    @(posedge Clk); #1; Reset_n = 1; idle();
    fetch(4'h1, 64'h0, 64'h2);
    n_checks++; if (PC !== 64'h0) begin n_fail++; $display("FAIL release_pc: got %h want 0", PC); end
    tick();
    n_checks++; if (PC !== 64'h2) begin n_fail++; $display("FAIL release_next: got %h want 2", PC); end
    do_reset();
  endtask

  task automatic test_nested_calls();
    logic [63:0] exp_pc [4]  = '{64'h100, 64'h200, 64'h109, 64'h9};
    logic [3:0]  exp_cnt [4] = '{4'd1, 4'd2, 4'd1, 4'd0};
    logic [3:0]  ic [4]      = '{4'h8, 4'h8, 4'h9, 4'h9};
    logic [63:0] vc [4]      = '{64'h100, 64'h200, 64'h0, 64'h0};
    logic [63:0] vp [4]      = '{64'h9, 64'h109, 64'h201, 64'h10a};
    for (int i = 0; i < 4; i++) begin
      fetch(ic[i], vc[i], vp[i]);
      tick();
      n_checks++;
      if (PC !== exp_pc[i] || ras_count !== exp_cnt[i]) begin
        n_fail++;
        $display("FAIL nested_%0d: got pc=%h cnt=%0d want pc=%h cnt=%0d", i, PC, ras_count, exp_pc[i], exp_cnt[i]);
      end
    end
    idle();
  endtask

  task automatic test_jxx_mispredict();
    fetch(4'h8, 64'h40, 64'h12); tick();
    fetch(4'h7, 64'h80, 64'h49); tick();
    n_checks++; if (PC !== 64'h80 || ras_count !== 4'd1) begin n_fail++; $display("FAIL jxx_taken: got pc=%h cnt=%0d want 80/1", PC, ras_count); end
    fetch(4'h8, 64'h300, 64'h89); tick();
    n_checks++; if (ras_count !== 4'd2) begin n_fail++; $display("FAIL wrong_path_push: got %0d want 2", ras_count); end
    fetch(4'h8, 64'h400, 64'h305);
    jxx_mispredict = 1; jxx_fall_pc = 64'h49;
    tick();
    jxx_mispredict = 0;
    n_checks++; if (PC !== 64'h49 || ras_count !== 4'd1) begin n_fail++; $display("FAIL jxx_restore: got pc=%h cnt=%0d want 49/1", PC, ras_count); end
    fetch(4'h9, 64'h0, 64'h4a);
    #1;
    n_checks++; if (pred_pc !== 64'h12) begin n_fail++; $display("FAIL jxx_ret_after: got %h want 12", pred_pc); end
    idle();
  endtask

  task automatic test_ret_mispredict();
    fetch(4'h8, 64'h50, 64'h9); tick();
    fetch(4'h9, 64'h0, 64'h51);
    #1;
    n_checks++; if (pred_pc !== 64'h9) begin n_fail++; $display("FAIL ret_pred: got %h want 9", pred_pc); end
    tick();
    F_stall = 1; fetch(4'h8, 64'h700, 64'h705);
    ret_resolve = 1; ret_actual_pc = 64'h30; ret_pred_pc = 64'h9;
    tick();
    idle();
    n_checks++; if (PC !== 64'h30 || ret_mispredict !== 1'b1 || ras_count !== 4'd0) begin
      n_fail++; $display("FAIL ret_fix: got pc=%h rm=%b cnt=%0d want 30/1/0", PC, ret_mispredict, ras_count);
    end
    fetch(4'h8, 64'h90, 64'h35);
    ret_resolve = 1; ret_actual_pc = 64'h77; ret_pred_pc = 64'h77;
    tick();
    idle();
    n_checks++; if (ret_mispredict !== 1'b0 || PC !== 64'h90 || ras_count !== 4'd1) begin
      n_fail++; $display("FAIL ret_ok: got rm=%b pc=%h cnt=%0d want 0/90/1", ret_mispredict, PC, ras_count);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      fetch(4'h8, 64'h1000 + 64'(i) * 64'h100, 64'h2000 + 64'(i));
      tick();
    end
    n_checks++; if (ras_overflow !== 1'b1 || ras_count !== 4'd8) begin n_fail++; $display("FAIL ovf_set: got ovf=%b cnt=%0d want 1/8", ras_overflow, ras_count); end
    for (int k = 0; k < 9; k++) begin
      logic [63:0] want;
      want = (k < 8) ? 64'h2000 + 64'(8 - k) : 64'h7777;
      fetch(4'h9, 64'h0, 64'h7777);
      tick();
      n_checks++;
      if (PC !== want) begin n_fail++; $display("FAIL ovf_ret_%0d: got %h want %h", k, PC, want); end
    end
    n_checks++; if (ras_count !== 4'd0 || ras_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_end: got cnt=%0d ovf=%b want 0/1", ras_count, ras_overflow); end
    idle();
  endtask

  task automatic test_priority();
    fetch(4'h8, 64'hA00, 64'hA1); tick();
    fetch(4'h8, 64'hB00, 64'hB1); tick();
    ret_resolve = 1; ret_actual_pc = 64'hC0; ret_pred_pc = 64'hC8;
    jxx_mispredict = 1; jxx_fall_pc = 64'hD0;
    tick();
    idle();
    n_checks++; if (PC !== 64'hC0 || ras_count !== 4'd0 || ret_mispredict !== 1'b1) begin
      n_fail++; $display("FAIL prio_ret_over_jxx: got pc=%h cnt=%0d rm=%b want C0/0/1", PC, ras_count, ret_mispredict);
    end
    fetch(4'h8, 64'hE00, 64'hE1); tick();
    for (int i = 0; i < 3; i++) begin
      F_stall = 1; fetch(4'h8, 64'hF00, 64'hF1);
      tick();
      n_checks++;
      if (PC !== 64'hE00 || ras_count !== 4'd1) begin n_fail++; $display("FAIL stall_%0d: got pc=%h cnt=%0d want E00/1", i, PC, ras_count); end
    end
    F_stall = 0; fetch(4'h9, 64'h0, 64'hE02);
    #1;
    n_checks++; if (pred_pc !== 64'hE1) begin n_fail++; $display("FAIL stall_ras_top: got %h want E1", pred_pc); end
    tick();
    idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      int r;
      r = $urandom_range(0, 9);
      f_valid = ($urandom_range(0, 9) != 0);
      f_icode = (r < 2) ? 4'h8 : (r < 4) ? 4'h9 : (r < 5) ? 4'h7 : 4'($urandom_range(0, 6));
      f_valC = {$urandom, $urandom}; f_valP = {$urandom, $urandom};
      F_stall = ($urandom_range(0, 5) == 0);
      jxx_mispredict = ($urandom_range(0, 9) == 0);
      jxx_fall_pc = {$urandom, $urandom};
      ret_resolve = ($urandom_range(0, 7) == 0);
      ret_pred_pc = {$urandom, $urandom};
      ret_actual_pc = ($urandom_range(0, 1) == 0) ? ret_pred_pc : {$urandom, $urandom};
      #1;
      n_checks++;
      if (PC !== m_pc || ras_count !== 4'(m_cnt) || ras_overflow !== m_ovf || ret_mispredict !== m_rm) begin
        n_fail++;
        $display("FAIL rand_state_%0d: got pc=%h cnt=%0d ovf=%b rm=%b want pc=%h cnt=%0d ovf=%b rm=%b",
                 n, PC, ras_count, ras_overflow, ret_mispredict, m_pc, m_cnt, m_ovf, m_rm);
      end
      n_checks++;
      if (pred_pc !== model_pred()) begin
        n_fail++; $display("FAIL rand_pred_%0d: got %h want %h", n, pred_pc, model_pred());
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_nested_calls();
    test_jxx_mispredict();
    test_ret_mispredict();
    test_overflow();
    test_priority();
    do_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
